// File: rtl/seq_divider.sv
// seq_divider: restoring sequential divider, one quotient bit per clock, signed/unsigned, defined divide-by-zero
module seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             finished,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count;
    logic [WIDTH:0]  rem, shifted, trial;
    logic [WIDTH-1:0] dvd, dmag, n_mag, d_mag;
    logic            q_neg, r_neg, dbz, sgn, n_neg, d_neg;

    // operand magnitudes and one restoring trial step
    always_comb begin
        sgn     = SIGNED_EN & is_signed;
        n_neg   = sgn & N[WIDTH-1];
        d_neg   = sgn & D[WIDTH-1];
        n_mag   = n_neg ? -N : N;
        d_mag   = d_neg ? -D : D;
        shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dmag};
    end

    // next state; busy covers both RUN and FIX
    always_comb begin
        state_nx = state;
        busy     = state != IDLE;
        if (state == IDLE && start)
            state_nx = (D == '0) ? FIX : RUN;
        else if (state == RUN && count == CW'(1))
            state_nx = FIX;
        else if (state == FIX)
            state_nx = IDLE;
    end

    // state register
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // datapath: operand capture, shift/subtract iterations, sign fix-up into the result registers
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rem         <= '0;
            dvd         <= '0;
            dmag        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz         <= 1'b0;
            Q           <= '0;
            R           <= '0;
            finished    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (state == IDLE && start) begin
                if (D == '0) begin
                    dvd   <= '1;
                    rem   <= {1'b0, N};
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                    dbz   <= 1'b1;
                end else begin
                    dvd   <= n_mag;
                    dmag  <= d_mag;
                    rem   <= '0;
                    q_neg <= n_neg ^ d_neg;
                    r_neg <= n_neg;
                    dbz   <= 1'b0;
                    count <= CW'(WIDTH);
                end
            end else if (state == RUN) begin
                count <= count - CW'(1);
                rem   <= trial[WIDTH] ? shifted : trial;
                dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
            end else if (state == FIX) begin
                Q           <= q_neg ? -dvd : dvd;
                R           <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                div_by_zero <= dbz;
                finished    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference
module tb_seq_divider;
    logic        ck = 1'b0;
    logic        rst_n = 1'b1;
    logic        ab_start = 1'b0, ab_s = 1'b0;
    logic [31:0] ab_n = '0, ab_d = '0;
    logic        c_start = 1'b0, c_s = 1'b0;
    logic [7:0]  c_n = '0, c_d = '0;
    logic [31:0] a_q, a_r, b_q, b_r;
    logic [7:0]  c_q, c_r;
    logic        a_busy, a_fin, a_dbz, b_busy, b_fin, b_dbz, c_busy, c_fin, c_dbz;
    logic [63:0] p_n, p_d;
    logic        p_s;
    int          n_chk = 0, n_err = 0;

    seq_divider #(.WIDTH(32), .SIGNED_EN(1)) u_a (
        .ck(ck), .rst_n(rst_n), .start(ab_start), .is_signed(ab_s), .N(ab_n), .D(ab_d),
        .Q(a_q), .R(a_r), .busy(a_busy), .finished(a_fin), .div_by_zero(a_dbz));
    seq_divider #(.WIDTH(32), .SIGNED_EN(0)) u_b (
        .ck(ck), .rst_n(rst_n), .start(ab_start), .is_signed(ab_s), .N(ab_n), .D(ab_d),
        .Q(b_q), .R(b_r), .busy(b_busy), .finished(b_fin), .div_by_zero(b_dbz));
    seq_divider #(.WIDTH(8), .SIGNED_EN(1)) u_c (
        .ck(ck), .rst_n(rst_n), .start(c_start), .is_signed(c_s), .N(c_n), .D(c_d),
        .Q(c_q), .R(c_r), .busy(c_busy), .finished(c_fin), .div_by_zero(c_dbz));

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // truncating division from plain integer arithmetic, w-bit results
    function automatic void ref_div(input int w, input bit s, input logic [63:0] n, input logic [63:0] d,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask;
        longint      sn, sd;
        mask = (64'd1 << w) - 64'd1;
        if (d == 0) begin
            q = mask;
            r = n & mask;
        end else if (s) begin
            sn = n[w-1] ? longint'(n) - (longint'(1) << w) : longint'(n);
            sd = d[w-1] ? longint'(d) - (longint'(1) << w) : longint'(d);
            q  = 64'(sn / sd) & mask;
            r  = 64'(sn % sd) & mask;
        end else begin
            q = (n / d) & mask;
            r = (n % d) & mask;
        end
    endfunction

    // called #1 after a rising edge; returns #1 after the sampling edge
    task automatic start_op(input bit w8, input logic [31:0] n, input logic [31:0] d, input bit s);
        p_n = w8 ? {56'd0, n[7:0]} : {32'd0, n};
        p_d = w8 ? {56'd0, d[7:0]} : {32'd0, d};
        p_s = s;
        if (w8) begin
            c_start = 1'b1; c_n = n[7:0]; c_d = d[7:0]; c_s = s;
        end else begin
            ab_start = 1'b1; ab_n = n; ab_d = d; ab_s = s;
        end
        @(posedge ck);
        #1;
        ab_start = 1'b0;
        c_start  = 1'b0;
        ab_n = $urandom; ab_d = $urandom; ab_s = 1'(s ^ 1'b1);
        c_n = 8'($urandom); c_d = 8'($urandom);
    endtask

    task automatic wait_op(input bit w8, input bit poke, input bit hold, input string tag);
        int          lat = 0, busy_cyc = 0, exp_lat;
        logic [63:0] eq, er, bq, br;
        exp_lat = (p_d == 0) ? 1 : (w8 ? 9 : 33);
        while (!(w8 ? c_fin : a_fin) && lat < 100) begin
            if (w8 ? c_busy : a_busy) busy_cyc++;
            if (poke && lat == 5) begin
                ab_start = 1'b1; ab_n = $urandom; ab_d = $urandom | 32'd1; ab_s = 1'($urandom);
            end
            @(posedge ck);
            #1;
            lat++;
            if (poke && lat == 6) ab_start = 1'b0;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
        if (w8) begin
            ref_div(8, p_s, p_n, p_d, eq, er);
            check({tag, "_q"}, {56'd0, c_q}, eq);
            check({tag, "_r"}, {56'd0, c_r}, er);
            check({tag, "_dbz"}, {63'd0, c_dbz}, {63'd0, p_d == 0});
            check({tag, "_busy_low"}, {63'd0, c_busy}, 64'd0);
        end else begin
            ref_div(32, p_s, p_n, p_d, eq, er);
            ref_div(32, 1'b0, p_n, p_d, bq, br);
            check({tag, "_q"}, {32'd0, a_q}, eq);
            check({tag, "_r"}, {32'd0, a_r}, er);
            check({tag, "_dbz"}, {63'd0, a_dbz}, {63'd0, p_d == 0});
            check({tag, "_busy_low"}, {63'd0, a_busy}, 64'd0);
            check({tag, "_u_fin"}, {63'd0, b_fin}, 64'd1);
            check({tag, "_u_q"}, {32'd0, b_q}, bq);
            check({tag, "_u_r"}, {32'd0, b_r}, br);
        end
        if (hold) begin
            @(posedge ck);
            #1;
            check({tag, "_fin_pulse"}, {63'd0, w8 ? c_fin : a_fin}, 64'd0);
            check({tag, "_q_hold"}, w8 ? {56'd0, c_q} : {32'd0, a_q}, eq);
        end
    endtask

    initial begin
        int fin_seen;
        #3 rst_n = 1'b0;
        #1;
        check("rst_q", {32'd0, a_q}, 64'd0);
        check("rst_r", {32'd0, a_r}, 64'd0);
        check("rst_busy", {63'd0, a_busy}, 64'd0);
        check("rst_fin", {63'd0, a_fin}, 64'd0);
        check("rst_dbz", {63'd0, a_dbz}, 64'd0);
        repeat (2) @(posedge ck);
        #1 rst_n = 1'b1;

        start_op(0, 32'd100, 32'd7, 0);
        wait_op(0, 0, 1, "u100_7");
        check("u100_7_const_q", {32'd0, a_q}, 64'd14);
        check("u100_7_const_r", {32'd0, a_r}, 64'd2);

        start_op(0, 32'hFFFF_FFF9, 32'd2, 1);
        wait_op(0, 0, 1, "s_m7_2");
        check("s_m7_2_const_q", {32'd0, a_q}, 64'hFFFF_FFFD);
        check("s_m7_2_const_r", {32'd0, a_r}, 64'hFFFF_FFFF);

        start_op(0, 32'hFFFF_FFF9, 32'd2, 0);
        wait_op(0, 0, 1, "u_m7_2");
        check("u_m7_2_const_q", {32'd0, a_q}, 64'h7FFF_FFFC);

        start_op(0, 32'd5, 32'd0, 1);
        wait_op(0, 0, 0, "dz5");
        check("dz5_const_q", {32'd0, a_q}, 64'hFFFF_FFFF);
        check("dz5_const_r", {32'd0, a_r}, 64'd5);
        check("dz5_const_dbz", {63'd0, a_dbz}, 64'd1);
        start_op(0, 32'd9, 32'd3, 0);
        wait_op(0, 0, 1, "b2b_9_3");
        check("b2b_9_3_const_q", {32'd0, a_q}, 64'd3);

        start_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_op(0, 0, 1, "ovf");
        check("ovf_const_q", {32'd0, a_q}, 64'h8000_0000);
        check("ovf_const_r", {32'd0, a_r}, 64'd0);

        start_op(0, 32'hFFFF_FFFF, 32'd2, 1);
        wait_op(0, 0, 1, "sen0");
        check("sen0_const_q", {32'd0, b_q}, 64'h7FFF_FFFF);
        check("sen0_const_r", {32'd0, b_r}, 64'd1);

        start_op(0, 32'd1234567, 32'd89, 0);
        wait_op(0, 1, 1, "poke");

        start_op(0, 32'hDEAD_BEEF, 32'h1234, 1);
        wait_op(0, 0, 0, "b2b_first");
        start_op(0, 32'd77777, 32'hFFFF_FFF0, 1);
        wait_op(0, 0, 1, "b2b_second");

        start_op(0, 32'd999999, 32'd13, 0);
        repeat (9) @(posedge ck);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_q", {32'd0, a_q}, 64'd0);
        check("mid_rst_r", {32'd0, a_r}, 64'd0);
        check("mid_rst_busy", {63'd0, a_busy}, 64'd0);
        check("mid_rst_dbz", {63'd0, a_dbz}, 64'd0);
        @(posedge ck);
        #1 rst_n = 1'b1;
        fin_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ck);
            #1;
            if (a_fin) fin_seen++;
        end
        check("mid_rst_no_fin", 64'(fin_seen), 64'd0);
        start_op(0, 32'd1000, 32'd10, 0);
        wait_op(0, 0, 1, "after_rst");
        check("after_rst_const_q", {32'd0, a_q}, 64'd100);

        start_op(1, 32'h80, 32'd3, 1);
        wait_op(1, 0, 1, "w8_m128_3");
        check("w8_const_q", {56'd0, c_q}, 64'hD6);
        check("w8_const_r", {56'd0, c_r}, 64'hFE);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] n, d;
            n = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
            d = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (i % 8 == 3) d = 32'hFFFF_FFFF;
            start_op(0, n, d, 1'($urandom));
            wait_op(0, 0, (i % 2) == 1, $sformatf("rnd32_%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            start_op(1, $urandom_range(0, 255), ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(0, 255),
                     1'($urandom));
            wait_op(1, 0, (i % 2) == 1, $sformatf("rnd8_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
